// File: rtl/vend_pkg.sv
// Shared types and money constants for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam int COIN5_VAL  = 5;
    localparam int COIN10_VAL = 10;
    localparam int CHG_VAL    = 5;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: coin accumulation with overflow rejection, price and change subtraction.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                coin_ok,
    input  logic                sub_price,
    input  logic [CREDIT_W-1:0] price,
    input  logic                sub_chg,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject
);

    // One extra bit so the overflow compare sees the true sum.
    logic [CREDIT_W:0] coin_sum;
    logic              coin_any;
    logic              overflow;
    logic              accept;

    always_comb begin
        coin_sum = {1'b0, credit};
        if (coin5) begin
            coin_sum = coin_sum + (CREDIT_W+1)'(COIN5_VAL);
        end
        if (coin10) begin
            coin_sum = coin_sum + (CREDIT_W+1)'(COIN10_VAL);
        end
    end

    assign coin_any = coin5 | coin10;
    assign overflow = coin_sum > (CREDIT_W+1)'(MAX_CREDIT);
    assign accept   = coin_any & coin_ok & ~overflow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_any & ~accept;
            if (sub_price) begin
                credit <= credit - price;
            end else if (sub_chg) begin
                credit <= credit - CREDIT_W'(CHG_VAL);
            end else if (accept) begin
                credit <= coin_sum[CREDIT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: selection/price check, dispense handshake, then change payout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100,
    parameter int NUM_PROD   = 4,
    localparam int ID_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         coin5,
    input  logic                         coin10,
    input  logic                         sel_valid,
    input  logic [ID_W-1:0]              sel_id,
    input  logic                         cancel,
    input  logic [NUM_PROD*CREDIT_W-1:0] price_tbl,
    output logic                         disp_req,
    output logic [ID_W-1:0]              disp_id,
    input  logic                         disp_ack,
    output logic                         chg_req,
    input  logic                         chg_ack,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy,
    output logic                         coin_reject,
    output logic                         err_short
);

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     disp_id_next;
    logic [CREDIT_W-1:0] price_sel;
    logic                err_next;
    logic                coin_ok;
    logic                sub_price;
    logic                sub_chg;

    always_comb begin
        price_sel = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_id == ID_W'(i)) begin
                price_sel = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Coins are only taken in IDLE cycles with no accepted cancel or sale.
    always_comb begin
        state_next   = state;
        disp_id_next = disp_id;
        err_next     = 1'b0;
        coin_ok      = 1'b0;
        sub_price    = 1'b0;
        sub_chg      = 1'b0;
        case (state)
            IDLE: begin
                if (cancel && credit != '0) begin
                    state_next = CHANGE;
                end else if (sel_valid && credit >= price_sel) begin
                    sub_price    = 1'b1;
                    disp_id_next = sel_id;
                    state_next   = DISPENSE;
                end else begin
                    err_next = sel_valid;
                    coin_ok  = 1'b1;
                end
            end
            DISPENSE: begin
                if (disp_ack) begin
                    state_next = (credit != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (chg_ack) begin
                    sub_chg = 1'b1;
                    if (credit <= CREDIT_W'(CHG_VAL)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            disp_req  <= 1'b0;
            chg_req   <= 1'b0;
            busy      <= 1'b0;
            err_short <= 1'b0;
            disp_id   <= '0;
        end else begin
            state     <= state_next;
            disp_req  <= (state_next == DISPENSE);
            chg_req   <= (state_next == CHANGE);
            busy      <= (state_next != IDLE);
            err_short <= err_next;
            disp_id   <= disp_id_next;
        end
    end

    vend_credit_acc #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin5       (coin5),
        .coin10      (coin10),
        .coin_ok     (coin_ok),
        .sub_price   (sub_price),
        .price       (price_sel),
        .sub_chg     (sub_chg),
        .credit      (credit),
        .coin_reject (coin_reject)
    );

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: directed stimulus pushes expected events, a monitor pops them.
module tb_vend_controller;

    localparam int CREDIT_W = 8;
    localparam int NUM_PROD = 4;
    localparam int ID_W     = 2;

    localparam int E_REJ  = 0;
    localparam int E_ERR  = 1;
    localparam int E_DISP = 2;
    localparam int E_CHG  = 3;
    localparam int E_IDLE = 4;
    localparam int E_PAY  = 5;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic                         coin5 = 1'b0;
    logic                         coin10 = 1'b0;
    logic                         sel_valid = 1'b0;
    logic [ID_W-1:0]              sel_id = '0;
    logic                         cancel = 1'b0;
    logic [NUM_PROD*CREDIT_W-1:0] price_tbl;
    logic                         disp_req;
    logic [ID_W-1:0]              disp_id;
    logic                         disp_ack = 1'b0;
    logic                         chg_req;
    logic                         chg_ack = 1'b0;
    logic [CREDIT_W-1:0]          credit;
    logic                         busy;
    logic                         coin_reject;
    logic                         err_short;

    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];
    string kname[6] = '{"reject", "err_short", "dispense", "change_start", "idle", "payout"};

    // Prices: p0=10, p1=20, p2=15, p3=0 (free).
    assign price_tbl = {8'd0, 8'd15, 8'd20, 8'd10};

    always #5 clk = ~clk;

    vend_controller #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (100),
        .NUM_PROD   (NUM_PROD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin5       (coin5),
        .coin10      (coin10),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .cancel      (cancel),
        .price_tbl   (price_tbl),
        .disp_req    (disp_req),
        .disp_id     (disp_id),
        .disp_ack    (disp_ack),
        .chg_req     (chg_req),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .busy        (busy),
        .coin_reject (coin_reject),
        .err_short   (err_short)
    );

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        coin5     = 1'b0;
        coin10    = 1'b0;
        sel_valid = 1'b0;
        cancel    = 1'b0;
        disp_ack  = 1'b0;
        chg_ack   = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Acks change coins from 'start' down to 0; optionally inserts a coin5 at step coin_step.
    task automatic pay_out(input int start, input int coin_step);
        int c;
        int k;
        c = start;
        k = 0;
        while (c > 0) begin
            push(E_PAY, c);
            chg_ack = 1'b1;
            if (k == coin_step) begin
                coin5 = 1'b1;
                push(E_REJ, c - 5);
            end
            if (c == 5) push(E_IDLE, 0);
            cyc();
            c = c - 5;
            k++;
        end
    endtask

    // Monitor: fixed in-cycle event order REJ, ERR, DISP, CHG, IDLE, PAY.
    task automatic observe(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s event: got val %0d expected none", kname[kind], val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                bad++;
                $display("FAIL event order/value: got %s val %0d expected %s val %0d",
                         kname[kind], val, kname[e.kind], e.val);
            end
        end
    endtask

    initial begin
        logic p_disp;
        logic p_chg;
        logic p_busy;
        p_disp = 1'b0;
        p_chg  = 1'b0;
        p_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (coin_reject === 1'b1) observe(E_REJ, int'(credit));
            if (err_short === 1'b1) observe(E_ERR, int'(credit));
            if (disp_req === 1'b1 && !p_disp) observe(E_DISP, (int'(disp_id) << 8) | int'(credit));
            if (chg_req === 1'b1 && !p_chg) observe(E_CHG, int'(credit));
            if (busy === 1'b0 && p_busy) observe(E_IDLE, int'(credit));
            if (chg_req === 1'b1 && chg_ack) observe(E_PAY, int'(credit));
            p_disp = (disp_req === 1'b1);
            p_chg  = (chg_req === 1'b1);
            p_busy = (busy === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        at_neg();
        chk("rst_credit", int'(credit), 0);
        chk("rst_disp_req", int'(disp_req), 0);
        chk("rst_chg_req", int'(chg_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_disp_id", int'(disp_id), 0);
        chk("rst_pulses", int'({coin_reject, err_short}), 0);
        reset_n = 1'b1;

        // Exact-credit sale, no change
        coin10 = 1'b1; cyc();
        coin10 = 1'b1; cyc();
        at_neg();
        chk("credit_20", int'(credit), 20);
        sel_id = 2'd1; sel_valid = 1'b1;
        push(E_DISP, (1 << 8) | 0);
        cyc();
        at_neg();
        chk("disp_req_next", int'(disp_req), 1);
        chk("disp_id_1", int'(disp_id), 1);
        chk("busy_disp", int'(busy), 1);
        cyc();
        at_neg();
        chk("disp_req_hold", int'(disp_req), 1);
        disp_ack = 1'b1;
        push(E_IDLE, 0);
        cyc();
        at_neg();
        chk("disp_req_low", int'(disp_req), 0);
        chk("no_chg_req", int'(chg_req), 0);

        // Ignored cancel at zero credit does not block the coin
        cancel = 1'b1; coin10 = 1'b1; cyc();
        at_neg();
        chk("cancel0_coin", int'(credit), 10);

        // Insufficient credit
        sel_id = 2'd2; sel_valid = 1'b1;
        push(E_ERR, 10);
        cyc();
        at_neg();
        chk("short_busy", int'(busy), 0);
        cyc();
        at_neg();
        chk("err_one_cycle", int'(err_short), 0);
        chk("short_credit", int'(credit), 10);
        sel_id = 2'd2; sel_valid = 1'b1; coin5 = 1'b1;
        push(E_ERR, 15);
        cyc();

        // Credit 25, price 15, two change coins
        coin10 = 1'b1; cyc();
        at_neg();
        chk("credit_25", int'(credit), 25);
        sel_id = 2'd2; sel_valid = 1'b1;
        push(E_DISP, (2 << 8) | 10);
        cyc();
        disp_ack = 1'b1;
        push(E_CHG, 10);
        cyc();
        pay_out(10, -1);
        chg_ack = 1'b1; cyc();
        at_neg();
        chk("stray_chg_ack", int'(credit), 0);

        // Coins with an accepted selection, and during DISPENSE, are refused
        coin10 = 1'b1; cyc();
        coin10 = 1'b1; cyc();
        sel_id = 2'd1; sel_valid = 1'b1; coin5 = 1'b1;
        push(E_REJ, 0);
        push(E_DISP, (1 << 8) | 0);
        cyc();
        disp_ack = 1'b1; coin5 = 1'b1;
        push(E_REJ, 0);
        push(E_IDLE, 0);
        cyc();

        // MAX_CREDIT boundary
        for (int i = 0; i < 9; i++) begin
            coin10 = 1'b1; cyc();
        end
        coin5 = 1'b1; cyc();
        at_neg();
        chk("credit_95", int'(credit), 95);
        coin10 = 1'b1;
        push(E_REJ, 95);
        cyc();
        at_neg();
        chk("reject_keep_95", int'(credit), 95);
        coin5 = 1'b1; cyc();
        at_neg();
        chk("credit_100", int'(credit), 100);
        chk("reject_one_cycle", int'(coin_reject), 0);
        coin5 = 1'b1;
        push(E_REJ, 100);
        cyc();
        cancel = 1'b1;
        push(E_CHG, 100);
        cyc();
        pay_out(100, -1);

        // Both coins in one cycle, then cancel with a coin during CHANGE
        coin5 = 1'b1; coin10 = 1'b1; cyc();
        at_neg();
        chk("credit_15", int'(credit), 15);
        cancel = 1'b1;
        push(E_CHG, 15);
        cyc();
        pay_out(15, 1);
        at_neg();
        chk("cancel_done_credit", int'(credit), 0);

        // Free product at zero credit
        sel_id = 2'd3; sel_valid = 1'b1;
        push(E_DISP, (3 << 8) | 0);
        cyc();
        disp_ack = 1'b1;
        push(E_IDLE, 0);
        cyc();

        // Reset during DISPENSE forfeits pending change
        for (int i = 0; i < 3; i++) begin
            coin10 = 1'b1; cyc();
        end
        sel_id = 2'd1; sel_valid = 1'b1;
        push(E_DISP, (1 << 8) | 10);
        cyc();
        reset_n = 1'b0;
        push(E_IDLE, 0);
        cyc();
        at_neg();
        chk("midrst_credit", int'(credit), 0);
        chk("midrst_outputs", int'({disp_req, chg_req, busy, coin_reject, err_short}), 0);
        chk("midrst_disp_id", int'(disp_id), 0);
        reset_n = 1'b1;
        disp_ack = 1'b1; cyc();
        cyc();
        at_neg();
        chk("stray_disp_ack", int'({disp_req, chg_req, busy}), 0);
        chk("stray_disp_credit", int'(credit), 0);

        repeat (3) cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Multi-product vending controller that sequences the coin-credit, dispense and change-return resources of the vending machine. It accumulates credit from 5- and 10-unit coin pulses and checks a selection against a per-product price table. On a successful sale it drives the dispense motor through a req/ack handshake, then pays out the remaining credit as 5-unit coins through a second req/ack handshake. It sits between the coin acceptor/keypad front end and the motor and hopper drivers.

## Interface
- `CREDIT_W`, 8: width of the credit and price values, in money units.
- `MAX_CREDIT`, 100: a coin that would push credit above this value is rejected.
- `NUM_PROD`, 4: number of products; `sel_id` and `disp_id` are `$clog2(NUM_PROD)` wide.
- `clk`  in  1  clock; the block uses one clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `coin5`  in  1  single-cycle pulse, 5-unit coin inserted.
- `coin10`  in  1  single-cycle pulse, 10-unit coin inserted.
- `sel_valid`  in  1  single-cycle pulse, product selected.
- `sel_id`  in  log2(NUM_PROD)  selected product index.
- `cancel`  in  1  single-cycle pulse, refund request.
- `price_tbl`  in  NUM_PROD*CREDIT_W  packed prices; product i occupies bits [i*CREDIT_W +: CREDIT_W]; each price is a multiple of 5.
- `disp_req`  out  1  dispense request to the motor.
- `disp_id`  out  log2(NUM_PROD)  product being dispensed.
- `disp_ack`  in  1  motor done.
- `chg_req`  out  1  request to pay out one 5-unit coin.
- `chg_ack`  in  1  coin paid out.
- `credit`  out  CREDIT_W  current credit, registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `coin_reject`  out  1  one-cycle pulse, coin refused.
- `err_short`  out  1  one-cycle pulse, selection refused for insufficient credit.

## Operation
- States are IDLE, DISPENSE and CHANGE. Reset enters IDLE.
- Reset values: every output is 0, including `credit` and `disp_id`.
- IDLE, priority order within one cycle:
  - `cancel` with credit > 0: go to CHANGE.
  - `cancel` with credit == 0: no effect.
  - `sel_valid` with credit >= price[`sel_id`]: credit -= price, latch `disp_id`, go to DISPENSE.
  - `sel_valid` with insufficient credit: pulse `err_short`, credit unchanged, stay in IDLE.
  - Coins: credit += 5*`coin5` + 10*`coin10`. Both pulses in one cycle add 15.
- Coin rejection rules:
  - In IDLE, if the sum would exceed `MAX_CREDIT`, reject all coins of that cycle: pulse `coin_reject`, credit unchanged.
  - Coins arriving in the same cycle as an accepted cancel or selection are rejected and `coin_reject` pulses. An ignored cancel (credit == 0) and a refused selection do not block that cycle's coins.
  - Coins arriving in DISPENSE or CHANGE are always rejected.
- DISPENSE:
  - `disp_req` holds at 1 until `disp_ack` is sampled high.
  - On ack: go to CHANGE if credit > 0, else go to IDLE.
  - `sel_valid` and `cancel` are ignored.
- CHANGE:
  - `chg_req` holds at 1 while in this state.
  - Each cycle with `chg_ack` high decrements credit by 5.
  - The ack that brings credit to 0 returns the block to IDLE.
  - `sel_valid` and `cancel` are ignored.
- `disp_ack` outside DISPENSE and `chg_ack` outside CHANGE are ignored.
- A price of 0 is legal: the sale dispenses for free.
- Arithmetic is unsigned at width `CREDIT_W`. Credit never underflows, because it changes only by the rules above.

## Timing
- Every output is registered.
- `disp_req`, `chg_req`, `busy` and `credit` change one cycle after the triggering input is sampled.
- `err_short` and `coin_reject` pulse exactly one cycle, in the cycle after the event.
- Selection to `disp_req` high: 1 cycle.
- `disp_ack` to `disp_req` low: 1 cycle. `chg_req` rises in that same cycle if change is due.
- `chg_ack` may stay high on consecutive cycles. Each high cycle pays out one coin, so the peak payout rate is one coin per cycle.
- Reset mid-sale (`reset_n` low at a clock edge): return to IDLE with credit 0 and all outputs 0 on that edge. Pending change is forfeited.

## Structure
- Shared package `vend_pkg` holds:
  - the state enum (IDLE, DISPENSE, CHANGE);
  - coin value constants `COIN5_VAL = 5` and `COIN10_VAL = 10`;
  - the change coin value `CHG_VAL = 5`.
- Sub-module `vend_credit_acc` is the natural split. It contains the credit register with add, subtract-price and subtract-change operations, plus the overflow/reject check. The FSM lives in `vend_controller`.

## Test plan
- coin10, coin10, then sel_id=1 with price 20 -> `disp_req` high next cycle with `disp_id`=1; ack -> IDLE with credit 0 and `chg_req` never asserted.
- Credit 25, select price 15 -> dispense, then CHANGE -> exactly 2 `chg_ack` handshakes (credit 10 -> 5 -> 0), then IDLE.
- Credit 10, select price 15 -> `err_short` pulses for 1 cycle, credit stays 10, state stays IDLE.
- Credit 95, coin10 -> `coin_reject` pulses and credit stays 95; coin5 -> credit 100. Separately, coin5 and coin10 in the same cycle from credit 0 -> credit 15.
- Credit 15, cancel -> 3 change handshakes then IDLE; a coin5 during CHANGE -> `coin_reject`, credit unaffected.
- `reset_n` low during DISPENSE -> IDLE with credit 0 and all outputs 0 on the next edge; a stray `disp_ack` afterwards is ignored.
